// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux selects
// and the control vector produced by the output decoder.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
               (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: current state to control vector. Only FETCH looks at
// mem_ready, so the IR and PC load on the cycle the fetch actually completes.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with unified-memory handshake and a
// retired-instruction counter.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  Op,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal_op,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    logic [3:0]  state_q, state_d, out_state;
    logic [31:0] count_q, count_d;
    logic        retire;
    ctrl_t       ctrl;

    // Outputs show FETCH values while reset is held, whatever state_q holds.
    assign out_state = rst ? S_FETCH : state_q;

    mc_output_decode u_decode (
        .state     (out_state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
            S_MEMWRITE:              retire = mem_ready;
            default:                 retire = 1'b0;
        endcase
    end

    assign count_d = count_q + {31'd0, retire};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign PCWrite     = ctrl.pc_update | (ctrl.branch & Zero);
    assign AdrSrc      = ctrl.adr_src;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign ResultSrc   = ctrl.result_src;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign illegal_op  = (out_state == S_DECODE) && !op_supported(Op);
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Op  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag, combinational from the datapath.
REQ-006 mem_ready  input  1  unified memory has completed the current access.
REQ-007 PCWrite  output  1  load the PC.
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IRWrite  output  1  load the instruction register and OldPC.
REQ-011 RegWrite  output  1  register file write enable.
REQ-012 ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
REQ-014 ALUSrcB  output  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
REQ-015 ALUOp  output  2  class code driving the existing ALU decoder: 00 add, 01 subtract/branch, 10 funct-decoded.
REQ-016 illegal_op  output  1  one-cycle pulse in DECODE when Op is unsupported.
REQ-017 instr_count  output  32  count of retired instructions.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PC update asserted only while mem_ready=1; stay in FETCH while mem_ready=0; when mem_ready=1, go to DECODE.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
REQ-022 DECODE next state by Op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> FETCH, with illegal_op=1 for that cycle.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD if Op=0000011, else MEMWRITE.
REQ-024 MEMREAD: AdrSrc=1, ResultSrc=00; hold in MEMREAD until mem_ready=1, then go to MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-026 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held for every cycle until mem_ready=1; next state FETCH.
REQ-027 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-028 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-030 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next state FETCH.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PC update=1; next state ALUWB.
REQ-032 Any output not listed for a state SHALL be 0.
REQ-033 PCWrite SHALL be (PC update term) OR (Branch AND Zero), computed combinationally in the same cycle.
REQ-034 instr_count SHALL increment by 1, wrapping modulo 2^32, on each edge that leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ toward FETCH.
REQ-035 An illegal opcode SHALL NOT increment instr_count.
REQ-036 Cycle counts per instruction with mem_ready tied to 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.

Reset
REQ-037 On any edge with rst=1: state=FETCH, instr_count=0, regardless of the current state or any pending memory wait.
REQ-038 During reset and in the first cycle after it, outputs SHALL be the FETCH values of REQ-020; illegal_op=0.

Structure
REQ-039 The shared package mc_pkg SHALL hold the state enumeration/encodings, the opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL) and the ALUOp class constants.
REQ-040 One combinational sub-module, mc_output_decode (state -> control vector), SHALL be used; the next-state logic and counter SHALL stay in the top module.
REQ-041 ALUOp SHALL feed the existing ALU decoder unchanged; this block SHALL NOT decode funct3/funct7.

Verification
REQ-042 Reset then Op=0000011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; instr_count=1.
REQ-043 Op=0100011, mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; instr_count +1.
REQ-044 Op=1100011 in BEQ with Zero=1 -> PCWrite=1; repeat with Zero=0 -> PCWrite=0; both runs retire (+1 each).
REQ-045 Op=1101111 -> FETCH, DECODE, JAL (PCWrite=1), ALUWB (RegWrite=1), FETCH.
REQ-046 Op=1111111 -> illegal_op pulse in DECODE, return to FETCH, instr_count unchanged.
REQ-047 rst=1 asserted while stalled in MEMREAD -> next state FETCH with instr_count=0; instr_count preloaded to 0xFFFFFFFF, then one ALUWB retire -> wraps to 0.
